irq_ctrl: RTL and testbench

//  Interrupt controller between the device IRQ lines (timer0, timer1, external interrupt, spares) and the CPU hwint input.

---
 rtl/irq_ctrl.sv | 109 ++++++++++
 tb/tb_irq_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches level/edge sources, masks them, resolves lowest-index priority, register access via sel/we.
// Latency: a source sampled at edge k shows in PEND/hwint/irq after edge k; register reads are combinational.
// Backpressure: none; every sel&we cycle is a single-cycle write that is always accepted.
module irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  src_irq,
    input  logic        sel,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [5:0]  hwint,
    output logic        irq
);

    // Bits at or above N_SRC are never stored, so they read back as 0 and never interrupt.
    localparam logic [5:0] SRC_MASK = 6'((7'd1 << N_SRC) - 7'd1);

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;
    localparam logic [1:0] REG_ID   = 2'd3;

    logic [5:0] pend_q;
    logic [5:0] mask_q;
    logic       gie_q;
    logic [5:0] mode_q;
    logic [5:0] prev_q;

    logic       wr_en;
    logic [1:0] reg_sel;
    logic [5:0] rise;
    logic [5:0] w1c;
    logic [5:0] pend_nxt;
    logic [5:0] hwint_int;
    logic       id_vld;
    logic [2:0] id_idx;

    // Only addr[3:2] and the low/top data bits are decoded; the rest is intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[30:6]};

    assign wr_en   = sel & we;
    assign reg_sel = addr[3:2];

    // Next pending: edge bits latch a rise and clear on W1C (rise wins), level bits mirror the source.
    always_comb begin
        rise     = src_irq & ~prev_q & SRC_MASK;
        w1c      = (wr_en && (reg_sel == REG_PEND)) ? wdata[5:0] : 6'd0;
        pend_nxt = ((mode_q & ((pend_q & ~w1c) | rise)) | (~mode_q & src_irq)) & SRC_MASK;
    end

    // State registers; reset overrides writes and source sampling.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 6'd0;
            mask_q <= 6'd0;
            gie_q  <= 1'b0;
            mode_q <= 6'd0;
            prev_q <= 6'd0;
        end else begin
            pend_q <= pend_nxt;
            prev_q <= src_irq & SRC_MASK;
            if (wr_en && (reg_sel == REG_MASK)) begin
                mask_q <= wdata[5:0] & SRC_MASK;
                gie_q  <= wdata[31];
            end
            if (wr_en && (reg_sel == REG_MODE)) begin
                mode_q <= wdata[5:0] & SRC_MASK;
            end
        end
    end

    // Masked vector; forced quiet while reset is held so outputs are 0 even before the first reset edge.
    always_comb begin
        hwint_int = gie_q ? (pend_q & mask_q) : 6'd0;
        hwint     = reset ? 6'd0 : hwint_int;
        irq       = |hwint;
    end

    // Lowest-numbered active source wins; index stays 0 when nothing is active.
    always_comb begin
        id_vld = |hwint;
        id_idx = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (hwint[i]) begin
                id_idx = 3'(i);
            end
        end
    end

    // Register read mux; unimplemented bits read 0, and everything reads 0 during reset.
    always_comb begin
        rdata = 32'd0;
        if (!reset) begin
            case (reg_sel)
                REG_PEND: rdata = {26'd0, pend_q};
                REG_MASK: rdata = {gie_q, 25'd0, mask_q};
                REG_MODE: rdata = {26'd0, mode_q};
                REG_ID:   rdata = {id_vld, 28'd0, id_idx};
                default:  rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then randomized traffic vs a per-source model.
// Inputs change 2 time units after each rising edge; outputs are compared on every falling edge.
// The model is updated at each rising edge from the inputs that the DUT sampled at that edge.
module tb_irq_ctrl;

    localparam int N = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  src;
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [5:0]  hwint;
    logic        irq;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b1;

    // Behavioural model: one flag per source and per control bit.
    bit m_pend [N];
    bit m_mask [N];
    bit m_mode [N];
    bit m_prev [N];
    bit m_gie;

    irq_ctrl #(.N_SRC(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src),
        .sel     (sel),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .hwint   (hwint),
        .irq     (irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit w1c;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_mask[i] = 0; m_mode[i] = 0; m_prev[i] = 0;
            end
            m_gie = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                w1c = sel && we && (addr[3:2] == 2'd0) && wdata[i];
                if (m_mode[i]) begin
                    if (src[i] && !m_prev[i]) m_pend[i] = 1;
                    else if (w1c)             m_pend[i] = 0;
                end else begin
                    m_pend[i] = src[i];
                end
            end
            if (sel && we && addr[3:2] == 2'd1) begin
                for (int i = 0; i < N; i++) m_mask[i] = wdata[i];
                m_gie = wdata[31];
            end
            if (sel && we && addr[3:2] == 2'd2) begin
                for (int i = 0; i < N; i++) m_mode[i] = wdata[i];
            end
            for (int i = 0; i < N; i++) m_prev[i] = src[i];
        end
    endtask

    function automatic logic [5:0] exp_hwint();
        logic [5:0] e = '0;
        if (!reset) begin
            for (int i = 0; i < N; i++) e[i] = m_gie && m_pend[i] && m_mask[i];
        end
        return e;
    endfunction

    function automatic logic [31:0] exp_rdata();
        logic [31:0] r = '0;
        logic [5:0]  h = exp_hwint();
        if (reset) return 32'd0;
        case (addr[3:2])
            2'd0: for (int i = 0; i < N; i++) r[i] = m_pend[i];
            2'd1: begin
                for (int i = 0; i < N; i++) r[i] = m_mask[i];
                r[31] = m_gie;
            end
            2'd2: for (int i = 0; i < N; i++) r[i] = m_mode[i];
            default: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (h[i]) r = 32'h8000_0000 | i;
                end
            end
        endcase
        return r;
    endfunction

    // Cycle compare against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_hwint", {26'd0, hwint}, {26'd0, exp_hwint()});
            check("cyc_irq",   {31'd0, irq},   {31'd0, |exp_hwint()});
            check("cyc_rdata", rdata,          exp_rdata());
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = {28'd0, r, 2'b00}; wdata = d;
        cyc();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] r, input logic [31:0] exp, input string nm);
        addr = {28'd0, r, 2'b00};
        #1;
        check(nm, rdata, exp);
    endtask

    initial begin
        reset = 1'b1; src = 6'h3F; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;

        // Reset with all sources high.
        repeat (3) cyc();
        check("rst_hwint", {26'd0, hwint}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd(2'd1, 32'd0, "rst_mask");
        rd(2'd2, 32'd0, "rst_mode");
        rd(2'd3, 32'd0, "rst_id");
        reset = 1'b0;
        cyc();
        rd(2'd0, 32'h3F, "pend_level_mirror");
        src = 6'h00;
        cyc();

        // Level source 0.
        wr(2'd1, 32'h8000_0003);
        src = 6'h01;
        cyc();
        check("lvl_hwint", {26'd0, hwint}, 32'h1);
        check("lvl_irq", {31'd0, irq}, 32'h1);
        rd(2'd3, 32'h8000_0000, "lvl_id");
        src = 6'h00;
        cyc();
        check("lvl_drop", {26'd0, hwint}, 32'h0);

        // Edge source 1: pulse latches, W1C clears.
        wr(2'd2, 32'h2);
        wr(2'd1, 32'h8000_0002);
        src = 6'h02;
        cyc();
        src = 6'h00;
        repeat (8) cyc();
        rd(2'd0, 32'h2, "edge_held");
        check("edge_irq", {31'd0, irq}, 32'h1);
        wr(2'd0, 32'h2);
        rd(2'd0, 32'h0, "edge_w1c");
        check("edge_w1c_irq", {31'd0, irq}, 32'h0);

        // Rise in the same cycle as W1C: set wins.
        src = 6'h02;
        cyc();
        src = 6'h00;
        cyc();
        src = 6'h02;
        wr(2'd0, 32'h2);
        rd(2'd0, 32'h2, "collision_pend");
        check("collision_irq", {31'd0, irq}, 32'h1);
        // Held-high source produces only one event.
        repeat (2) cyc();
        wr(2'd0, 32'h2);
        repeat (2) cyc();
        rd(2'd0, 32'h0, "held_no_rearm");
        src = 6'h00;
        cyc();

        // Priority among edge bits 3 and 5.
        wr(2'd2, 32'h2A);
        wr(2'd1, 32'h8000_0028);
        src = 6'h28;
        cyc();
        src = 6'h00;
        cyc();
        rd(2'd3, 32'h8000_0003, "prio_3");
        wr(2'd0, 32'h8);
        rd(2'd3, 32'h8000_0005, "prio_5");
        wr(2'd0, 32'h20);
        rd(2'd3, 32'h0, "prio_none");

        // Global enable off.
        wr(2'd1, 32'h0000_003F);
        src = 6'h28;
        cyc();
        src = 6'h00;
        cyc();
        check("gie_off_hwint", {26'd0, hwint}, 32'h0);
        check("gie_off_irq", {31'd0, irq}, 32'h0);
        rd(2'd0, 32'h28, "gie_off_pend");
        wr(2'd1, 32'h8000_003F);
        check("gie_on_irq", {31'd0, irq}, 32'h1);
        check("gie_on_hwint", {26'd0, hwint}, 32'h28);

        // Randomized traffic including occasional resets.
        for (int k = 0; k < 800; k++) begin
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) src = 6'($urandom);
            sel   = ($urandom_range(0, 2) == 0);
            we    = ($urandom_range(0, 1) == 0);
            addr  = $urandom;
            wdata = $urandom;
            if ($urandom_range(0, 1) == 0) wdata[31] = 1'b1;
            cyc();
        end
        reset = 1'b0; sel = 1'b0; we = 1'b0;
        cyc();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
